// File: rtl/cmd_encoder_pkg.sv
// Shared definitions for the command encoder and its matching decoder:
// op codes, frame field positions and the frame/checksum builders.
package cmd_encoder_pkg;

   localparam logic [2:0] OP_ON      = 3'd1;
   localparam logic [2:0] OP_OFF     = 3'd2;
   localparam logic [2:0] OP_INC     = 3'd3;
   localparam logic [2:0] OP_DEC     = 3'd4;
   localparam logic [2:0] OP_SEND    = 3'd5;
   localparam logic [2:0] OP_RECEIVE = 3'd6;

   localparam logic [7:0] HEADER = 8'hA5;

   localparam int FRAME_W  = 32;
   localparam int HDR_LSB  = 24;
   localparam int OP_LSB   = 20;
   localparam int AMT_LSB  = 12;
   localparam int SEQ_LSB  = 8;
   localparam int CSUM_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_HOLD,
      ST_GAP
   } enc_state_t;

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] amount;
   } cmd_req_t;

   function automatic logic op_is_legal(input logic [2:0] op);
      return (op >= OP_ON) && (op <= OP_RECEIVE);
   endfunction

   // Checksum covers frame bits [31:8] as three bytes.
   function automatic logic [7:0] frame_checksum(input logic [23:0] upper);
      return upper[23:16] ^ upper[15:8] ^ upper[7:0];
   endfunction

   function automatic logic [FRAME_W-1:0] build_frame(input cmd_req_t req, input logic [3:0] seq);
      logic [FRAME_W-1:0] f;
      logic [7:0]         amt;
      amt = (req.op == OP_INC || req.op == OP_DEC) ? req.amount : 8'h00;
      f = '0;
      f[HDR_LSB +: 8]  = HEADER;
      f[OP_LSB +: 4]   = {1'b0, req.op};
      f[AMT_LSB +: 8]  = amt;
      f[SEQ_LSB +: 4]  = seq;
      f[CSUM_LSB +: 8] = frame_checksum(f[FRAME_W-1:8]);
      return f;
   endfunction

endpackage

// File: rtl/cmd_encoder_fifo.sv
// Small synchronous show-ahead FIFO; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module cmd_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   assign empty   = (r_wr_ptr == r_rd_ptr);
   assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push  = wr_en && !full;
   assign w_pop   = rd_en && !empty;
   assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/cmd_encoder.sv
// Host-side command transmitter: queues op requests and drives each as a
// framed, checksummed word for a fixed hold time followed by an idle gap.
module cmd_encoder
   import cmd_encoder_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int QDEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_op,
   input  logic [7:0]            req_amount,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_active,
   output logic                  busy,
   output logic                  err_illegal,
   output logic [3:0]            seq
);

   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;

   enc_state_t            r_state;
   enc_state_t            w_state_next;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_next;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic [DATA_WIDTH-1:0] w_tx_data_next;
   logic                  r_tx_active;
   logic                  w_tx_active_next;
   logic [3:0]            r_seq;
   logic [3:0]            w_seq_next;
   logic                  r_err;

   logic                  w_accept;
   logic                  w_legal;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   cmd_req_t              w_wr_req;
   cmd_req_t              w_rd_req;

   assign w_accept = req_valid && req_ready;
   assign w_legal  = op_is_legal(req_op);
   assign w_wr_req = '{op: req_op, amount: req_amount};

   // Illegal ops complete the handshake but never reach the queue.
   cmd_fifo #(
      .WIDTH ($bits(cmd_req_t)),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_accept && w_legal),
      .wr_data (w_wr_req),
      .rd_en   (w_pop),
      .rd_data (w_rd_req),
      .full    (w_full),
      .empty   (w_empty)
   );

   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_tx_data_next   = r_tx_data;
      w_tx_active_next = r_tx_active;
      w_seq_next       = r_seq;
      w_pop            = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) w_state_next = ST_LOAD;
         end
         ST_LOAD: begin
            w_pop            = 1'b1;
            w_tx_data_next   = DATA_WIDTH'(build_frame(w_rd_req, r_seq));
            w_tx_active_next = 1'b1;
            w_cnt_next       = '0;
            w_state_next     = ST_HOLD;
         end
         ST_HOLD: begin
            if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
               w_tx_data_next   = '0;
               w_tx_active_next = 1'b0;
               w_seq_next       = r_seq + 4'd1;
               w_cnt_next       = '0;
               w_state_next     = ST_GAP;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         ST_GAP: begin
            if (r_cnt == CW'(GAP_CYCLES - 1)) begin
               w_cnt_next   = '0;
               w_state_next = w_empty ? ST_IDLE : ST_LOAD;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_tx_data   <= '0;
         r_tx_active <= 1'b0;
         r_seq       <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_tx_data   <= w_tx_data_next;
         r_tx_active <= w_tx_active_next;
         r_seq       <= w_seq_next;
         r_err       <= w_accept && !w_legal;
      end
   end

   assign req_ready   = !w_full;
   assign tx_data     = r_tx_data;
   assign tx_active   = r_tx_active;
   assign busy        = !w_empty || (r_state != ST_IDLE);
   assign err_illegal = r_err;
   assign seq         = r_seq;

endmodule

// File: tb/tb_cmd_encoder.sv
// Directed bench for cmd_encoder: stimulus pushes expected frames into a
// scoreboard queue, an independent monitor pops them as frames appear.
module tb_cmd_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [2:0]  req_op = 3'd0;
   logic [7:0]  req_amount = 8'd0;
   logic        req_ready;
   logic [31:0] tx_data;
   logic        tx_active;
   logic        busy;
   logic        err_illegal;
   logic [3:0]  seq;

   cmd_encoder #(
      .DATA_WIDTH  (32),
      .HOLD_CYCLES (4),
      .GAP_CYCLES  (2),
      .QDEPTH      (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_amount  (req_amount),
      .tx_data     (tx_data),
      .tx_active   (tx_active),
      .busy        (busy),
      .err_illegal (err_illegal),
      .seq         (seq)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          pcyc = 0;
   int          frames_seen = 0;
   int          last_accept = 0;
   logic [31:0] exp_q[$];
   int          start_q[$];
   logic [3:0]  tb_seq = 4'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] op, input logic [7:0] amt, input logic [3:0] s);
      logic [31:0] w;
      logic [7:0]  a;
      a = (op == 3'd3 || op == 3'd4) ? amt : 8'h00;
      w = {8'hA5, 1'b0, op, a, s, 8'h00};
      w[7:0] = w[31:24] ^ w[23:16] ^ w[15:8];
      return w;
   endfunction

   initial forever begin
      @(posedge clk);
      pcyc++;
   end

   // Monitor: compares each new frame against the scoreboard head.
   initial begin : monitor
      logic        prev_act;
      logic [31:0] cur_word;
      int          run_len;
      prev_act = 1'b0;
      cur_word = '0;
      run_len  = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_act = 1'b0;
         end else begin
            if (tx_active) begin
               if (!prev_act) begin
                  frames_seen++;
                  start_q.push_back(pcyc);
                  $display("frame %0d at cycle %0d: %h", frames_seen, pcyc, tx_data);
                  if (exp_q.size() == 0) begin
                     n_vec++;
                     n_err++;
                     $display("FAIL unexpected_frame: got %h, expected none", tx_data);
                  end else begin
                     chk("frame_word", tx_data, exp_q.pop_front());
                  end
                  cur_word = tx_data;
                  run_len  = 1;
               end else begin
                  run_len++;
                  if (tx_data !== cur_word) chk("hold_stable", tx_data, cur_word);
               end
            end else if (prev_act) begin
               chk("hold_len", 32'(run_len), 32'd4);
               chk("idle_word", tx_data, 32'd0);
            end
            prev_act = tx_active;
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_core(input logic [2:0] op, input logic [7:0] amt, input logic [31:0] word);
      int   t;
      logic legal;
      legal      = (op >= 3'd1) && (op <= 3'd6);
      req_valid  = 1'b1;
      req_op     = op;
      req_amount = amt;
      t = 0;
      while (!req_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (legal) begin
         exp_q.push_back(word);
         tb_seq = tb_seq + 4'd1;
      end
      @(negedge clk);
      last_accept = pcyc;
      req_valid   = 1'b0;
      $display("request op=%0d amount=%h accepted at cycle %0d", op, amt, pcyc);
      chk("err_illegal", 32'(err_illegal), 32'(!legal));
   endtask

   task automatic send(input logic [2:0] op, input logic [7:0] amt);
      send_core(op, amt, model(op, amt, tb_seq));
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while ((busy || tx_active) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("drain_timeout", 32'(busy || tx_active), 32'd0);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      tb_seq = 4'd0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int          t;
      int          acc5;
      int          fs;
      logic [3:0]  s0;
      logic [2:0]  ops5 [6];
      logic [7:0]  amts5 [6];
      ops5  = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd2, 3'd1};
      amts5 = '{8'h01, 8'h02, 8'h33, 8'h44, 8'h55, 8'h66};

      repeat (3) @(negedge clk);
      chk("rst_tx_data", tx_data, 32'd0);
      chk("rst_tx_active", 32'(tx_active), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err_illegal), 32'd0);
      chk("rst_seq", 32'(seq), 32'd0);
      rst = 1'b0;
      tb_seq = 4'd0;

      // Single INC 0x3C: latency 2, literal frame.
      start_q.delete();
      send_core(3'd3, 8'h3C, 32'hA533C056);
      wait_idle();
      if (start_q.size() >= 1) chk("latency", 32'(start_q[0] - last_accept), 32'd2);
      else chk("latency_no_frame", 32'(start_q.size()), 32'd1);
      chk("seq_after_one", 32'(seq), 32'd1);

      // ON with nonzero amount: amount field forced to zero.
      do_reset();
      send_core(3'd1, 8'hFF, 32'hA51000B5);
      wait_idle();

      // Back-to-back burst filling the queue.
      start_q.delete();
      for (int i = 0; i < 5; i++) send(ops5[i], amts5[i]);
      chk("ready_full", 32'(req_ready), 32'd0);
      chk("busy_burst", 32'(busy), 32'd1);
      acc5 = last_accept;
      send(ops5[5], amts5[5]);
      chk("push_refused_until_pop", 32'(last_accept - acc5), 32'd6);
      wait_idle();
      chk("burst_frames", 32'(start_q.size()), 32'd6);
      if (start_q.size() == 6)
         for (int i = 1; i < 6; i++) chk("frame_period", 32'(start_q[i] - start_q[i-1]), 32'd7);

      // Illegal ops: one pulse each, no frame, seq unchanged.
      s0 = seq;
      fs = frames_seen;
      send(3'd0, 8'h12);
      chk("err_pulse_end0", 32'(err_illegal), 32'd1);
      @(negedge clk);
      chk("err_one_cycle0", 32'(err_illegal), 32'd0);
      send(3'd7, 8'h34);
      @(negedge clk);
      chk("err_one_cycle7", 32'(err_illegal), 32'd0);
      repeat (10) @(negedge clk);
      chk("illegal_no_frame", 32'(frames_seen - fs), 32'd0);
      chk("illegal_seq", 32'(seq), 32'(s0));
      chk("illegal_busy", 32'(busy), 32'd0);

      // 17 frames: seq wraps 15 -> 0.
      do_reset();
      fs = frames_seen;
      for (int i = 0; i < 17; i++) send((i % 2 == 0) ? 3'd3 : 3'd4, 8'(i * 23 + 7));
      wait_idle();
      chk("wrap_frames", 32'(frames_seen - fs), 32'd17);
      chk("wrap_seq", 32'(seq), 32'd1);

      // Reset during third HOLD cycle with two requests still queued.
      do_reset();
      send(3'd3, 8'hAA);
      send(3'd4, 8'hBB);
      send(3'd5, 8'hCC);
      t = 0;
      while (!tx_active && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("midframe_started", 32'(tx_active), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_tx_data", tx_data, 32'd0);
      chk("midrst_tx_active", 32'(tx_active), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_seq", 32'(seq), 32'd0);
      rst = 1'b0;
      exp_q.delete();
      tb_seq = 4'd0;
      fs = frames_seen;
      repeat (40) @(negedge clk);
      chk("midrst_no_frames", 32'(frames_seen - fs), 32'd0);
      chk("midrst_busy_after", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
